// File: rtl/vend_ctrl.sv
// Vending-machine controller: coin collection, vend, change payout through a hopper.
// Optional hopper-timeout fault detection is enabled by defining VEND_HOP_TIMEOUT_EN.
module vend_ctrl #(
  parameter int PRICE   = 5,
  parameter int TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] coin,
  input  logic       cancel,
  input  logic       hop_ack,
  output logic       hop_req,
  output logic       shipping,
  output logic [4:0] credit,
  output logic [4:0] pay_cnt,
  output logic       coin_rej,
  output logic       err
);

  typedef enum logic [2:0] {S_IDLE, S_COLLECT, S_VEND, S_PAYOUT, S_ERROR} state_t;

  localparam logic [4:0] P  = 5'(PRICE);
  localparam logic [7:0] TO = 8'(TIMEOUT);

  state_t     state, nxt_state;
  logic [4:0] val, sum;
  logic       valid, taking, timeout_hit;
  logic [4:0] credit_d, pay_d;
  logic       ship_d, hop_d, rej_d, err_d;

  always_comb begin
    val = 5'd0;
    case (coin)
      3'b001:  val = 5'd1;
      3'b011:  val = 5'd2;
      3'b101:  val = 5'd10;
      default: val = 5'd0;
    endcase
  end

  assign valid  = (val != 5'd0);
  assign taking = (state == S_IDLE) || (state == S_COLLECT);
  // credit never exceeds PRICE-1 before a coin, so the sum fits in 5 bits
  assign sum    = credit + val;

`ifdef VEND_HOP_TIMEOUT_EN
  logic [7:0] tcnt, tcnt_d;
  assign tcnt_d      = (state == S_PAYOUT && hop_req && !hop_ack) ? tcnt + 8'd1 : 8'd0;
  assign timeout_hit = (state == S_PAYOUT) && (tcnt_d == TO);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) tcnt <= 8'd0;
    else        tcnt <= tcnt_d;
`else
  logic unused_cfg;
  assign unused_cfg  = ^TO;
  assign timeout_hit = 1'b0;
`endif

  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_IDLE;
    else        state <= nxt_state;

  // next-state logic
  always_comb begin
    nxt_state = state;
    case (state)
      S_IDLE, S_COLLECT: begin
        if (valid && sum >= P)                 nxt_state = S_VEND;
        else if (state == S_COLLECT && cancel) nxt_state = S_PAYOUT;
        else if (valid)                        nxt_state = S_COLLECT;
      end
      S_VEND:   nxt_state = (credit > P) ? S_PAYOUT : S_IDLE;
      S_PAYOUT: begin
        if (hop_ack && pay_cnt == 5'd1) nxt_state = S_IDLE;
        else if (timeout_hit)           nxt_state = S_ERROR;
      end
      S_ERROR:  nxt_state = S_ERROR;
      default:  nxt_state = S_IDLE;
    endcase
  end

  // next values of the registered outputs
  always_comb begin
    credit_d = credit;
    pay_d    = pay_cnt;
    rej_d    = (coin != 3'b000) && (!valid || !taking);
    case (state)
      S_IDLE, S_COLLECT: begin
        if (valid && sum >= P)                 credit_d = sum;
        else if (state == S_COLLECT && cancel) begin
          pay_d    = sum;
          credit_d = 5'd0;
        end
        else if (valid)                        credit_d = sum;
      end
      S_VEND: begin
        pay_d    = credit - P;
        credit_d = 5'd0;
      end
      S_PAYOUT: if (hop_ack) pay_d = pay_cnt - 5'd1;
      default: ;
    endcase
    ship_d = (nxt_state == S_VEND);
    hop_d  = (nxt_state == S_PAYOUT);
    err_d  = err || (nxt_state == S_ERROR);
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      credit   <= 5'd0;
      pay_cnt  <= 5'd0;
      shipping <= 1'b0;
      hop_req  <= 1'b0;
      coin_rej <= 1'b0;
      err      <= 1'b0;
    end else begin
      credit   <= credit_d;
      pay_cnt  <= pay_d;
      shipping <= ship_d;
      hop_req  <= hop_d;
      coin_rej <= rej_d;
      err      <= err_d;
    end

endmodule

// File: tb/tb_vend_ctrl.sv
// Directed, table-driven bench for vend_ctrl (PRICE=5, TIMEOUT=8).
// Timeout checks follow VEND_HOP_TIMEOUT_EN, matching the RTL build.
module tb_vend_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] coin = 3'b000;
  logic       cancel = 1'b0;
  logic       hop_ack = 1'b0;
  logic       hop_req, shipping, coin_rej, err;
  logic [4:0] credit, pay_cnt;

  int checks = 0;
  int errors = 0;

  vend_ctrl #(.PRICE(5), .TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n), .coin(coin), .cancel(cancel), .hop_ack(hop_ack),
    .hop_req(hop_req), .shipping(shipping), .credit(credit), .pay_cnt(pay_cnt),
    .coin_rej(coin_rej), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] coin;
    logic       cancel;
    logic       ack;
    logic       ship;
    logic       hop;
    logic [4:0] cr;
    logic [4:0] pc;
    logic       rej;
  } vec_t;

  vec_t vecs[$];

  // {shipping, hop_req, credit, pay_cnt, coin_rej, err}
  function automatic logic [13:0] pack(logic s, logic h, logic [4:0] c, logic [4:0] p, logic r, logic e);
    return {s, h, c, p, r, e};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic [2:0] c, input logic can, input logic a);
    @(negedge clk);
    coin = c; cancel = can; hop_ack = a;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic [2:0] c, input logic can, input logic a,
                     input logic s, input logic h, input logic [4:0] cr, input logic [4:0] pc, input logic r);
    vec_t v;
    v.coin = c; v.cancel = can; v.ack = a; v.ship = s; v.hop = h; v.cr = cr; v.pc = pc; v.rej = r;
    vecs.push_back(v);
  endtask

  // asynchronous reset assertion away from any clock edge, then release
  task automatic async_reset(input string name);
    @(negedge clk);
    coin = 3'b000; cancel = 1'b0; hop_ack = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk(name, pack(shipping, hop_req, credit, pay_cnt, coin_rej, err), 14'd0);
    @(posedge clk); #1;
    chk({name, "_held"}, pack(shipping, hop_req, credit, pay_cnt, coin_rej, err), 14'd0);
    @(negedge clk) rst_n = 1'b1;
  endtask

  initial begin
    int exp_pc;
    // coins 001,011,011 -> credit 1,3,5, one-cycle vend, no change
    add(3'b001,0,0, 0,0,1,0,0);
    add(3'b011,0,0, 0,0,3,0,0);
    add(3'b011,0,0, 1,0,5,0,0);
    add(3'b000,0,0, 0,0,0,0,0);
    add(3'b000,0,0, 0,0,0,0,0);
    // cancel with same-cycle coin -> refund 3, reject coin during payout
    add(3'b011,0,0, 0,0,2,0,0);
    add(3'b001,1,0, 0,1,0,3,0);
    add(3'b000,0,0, 0,1,0,3,0);
    add(3'b000,0,1, 0,1,0,2,0);
    add(3'b101,0,0, 0,1,0,2,1);
    add(3'b000,0,1, 0,1,0,1,0);
    add(3'b000,0,1, 0,0,0,0,0);
    // invalid code in IDLE, stray ack and cancel in IDLE
    add(3'b010,0,0, 0,0,0,0,1);
    add(3'b000,0,1, 0,0,0,0,0);
    add(3'b000,1,0, 0,0,0,0,0);
    // cancel on the vend-triggering cycle loses; coin during VEND rejected
    add(3'b001,0,0, 0,0,1,0,0);
    add(3'b101,1,0, 1,0,11,0,0);
    add(3'b011,0,0, 0,1,0,6,1);
    add(3'b000,0,1, 0,1,0,5,0);
    add(3'b000,0,1, 0,1,0,4,0);
    add(3'b000,0,1, 0,1,0,3,0);
    add(3'b000,0,1, 0,1,0,2,0);
    add(3'b000,0,1, 0,1,0,1,0);
    add(3'b000,0,1, 0,0,0,0,0);
    // maximum credit PRICE-1+10 = 14 -> change 9
    add(3'b011,0,0, 0,0,2,0,0);
    add(3'b011,0,0, 0,0,4,0,0);
    add(3'b101,0,0, 1,0,14,0,0);
    add(3'b000,0,0, 0,1,0,9,0);

    repeat (2) @(posedge clk);
    #1 chk("reset_state", pack(shipping, hop_req, credit, pay_cnt, coin_rej, err), 14'd0);
    @(negedge clk) rst_n = 1'b1;

    foreach (vecs[i]) begin
      step(vecs[i].coin, vecs[i].cancel, vecs[i].ack);
      chk($sformatf("vec%0d", i), pack(shipping, hop_req, credit, pay_cnt, coin_rej, err),
          pack(vecs[i].ship, vecs[i].hop, vecs[i].cr, vecs[i].pc, vecs[i].rej, 1'b0));
    end

    // now in PAYOUT with 9 units owed and no acks arriving
`ifdef VEND_HOP_TIMEOUT_EN
    for (int i = 1; i < 8; i++) begin
      step(3'b000, 0, 0);
      chk($sformatf("to_wait%0d", i), pack(shipping, hop_req, credit, pay_cnt, coin_rej, err),
          pack(0,1,0,9,0,0));
    end
    step(3'b000, 0, 0);
    chk("to_fault", pack(shipping, hop_req, credit, pay_cnt, coin_rej, err), pack(0,0,0,9,0,1));
    step(3'b011, 0, 0);
    chk("to_coin_rej", pack(shipping, hop_req, credit, pay_cnt, coin_rej, err), pack(0,0,0,9,1,1));
    step(3'b000, 1, 1);
    chk("to_sticky", pack(shipping, hop_req, credit, pay_cnt, coin_rej, err), pack(0,0,0,9,0,1));
`else
    for (int i = 0; i < 20; i++) step(3'b000, 0, 0);
    chk("no_timeout", pack(shipping, hop_req, credit, pay_cnt, coin_rej, err), pack(0,1,0,9,0,0));
`endif
    async_reset("rst_clear");

    // coin 101 -> 5 units change, ack every third cycle
    step(3'b101, 0, 0);
    chk("r030_ship", pack(shipping, hop_req, credit, pay_cnt, coin_rej, err), pack(1,0,10,0,0,0));
    step(3'b000, 0, 0);
    chk("r030_start", pack(shipping, hop_req, credit, pay_cnt, coin_rej, err), pack(0,1,0,5,0,0));
    exp_pc = 5;
    for (int k = 0; k < 60 && exp_pc > 0; k++) begin
      logic a;
      a = (k % 3 == 2);
      step(3'b000, 0, a);
      if (a) exp_pc--;
      chk($sformatf("r030_k%0d", k), {shipping, hop_req, pay_cnt}, {1'b0, exp_pc != 0, 5'(exp_pc)});
    end
    step(3'b000, 0, 1);
    chk("r030_idle", pack(shipping, hop_req, credit, pay_cnt, coin_rej, err), 14'd0);

    // reset mid-payout with 3 units still owed
    step(3'b101, 0, 0);
    step(3'b000, 0, 0);
    step(3'b000, 0, 1);
    step(3'b000, 0, 1);
    chk("r034_pre", pack(shipping, hop_req, credit, pay_cnt, coin_rej, err), pack(0,1,0,3,0,0));
    async_reset("r034_async");
    step(3'b000, 0, 0);
    chk("r034_after", pack(shipping, hop_req, credit, pay_cnt, coin_rej, err), 14'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vend_ctrl.md
VEND_CTRL -- requirements
Module: vend_ctrl

Interface
REQ-001 Parameter PRICE, default 5, item price in half-yuan units (1..15).
REQ-002 Parameter TIMEOUT, default 255, max cycles hop_req may wait for hop_ack (1..255).
REQ-003 clk  input  1  single system clock, all state on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 coin  input  3  coin code per cycle: 3'b000 none; 3'b001 0.5 yuan (1 unit); 3'b011 1 yuan (2 units); 3'b101 5 yuan (10 units); other codes invalid.
REQ-006 cancel  input  1  level, request refund of current credit.
REQ-007 hop_ack  input  1  change hopper has ejected one 0.5-yuan coin (one-cycle pulse).
REQ-008 hop_req  output  1  request hopper to eject one 0.5-yuan coin.
REQ-009 shipping  output  1  one-cycle pulse, release item.
REQ-010 credit  output  5  current accumulated credit in units.
REQ-011 pay_cnt  output  5  change units still to dispense.
REQ-012 coin_rej  output  1  one-cycle pulse, coin of the previous cycle not accepted.
REQ-013 err  output  1  hopper timeout fault, sticky.

Function
REQ-014 States SHALL be IDLE, COLLECT, VEND, PAYOUT, ERROR; encoding free.
REQ-015 IDLE/COLLECT, valid coin: credit <= credit + value; state COLLECT; if credit+value >= PRICE, next state VEND.
REQ-016 VEND (exactly one cycle): shipping = 1; pay_cnt <= credit - PRICE; credit <= 0; next PAYOUT if credit > PRICE, else IDLE.
REQ-017 Max credit is PRICE-1+10 (<= 24); 5-bit arithmetic SHALL never wrap.
REQ-018 cancel in COLLECT: pay_cnt <= credit + value of same-cycle valid coin; credit <= 0; next PAYOUT; no shipping.
REQ-019 cancel in IDLE, or in any other state, SHALL be ignored; cancel on the cycle that makes credit >= PRICE is ignored (vend wins).
REQ-020 PAYOUT: hop_req = 1 while pay_cnt > 0; each cycle with hop_ack = 1 decrements pay_cnt by 1; the cycle pay_cnt reaches 0 state returns to IDLE and hop_req deasserts next cycle.
REQ-021 hop_ack outside PAYOUT SHALL be ignored.
REQ-022 Coins in VEND, PAYOUT, ERROR, and invalid codes in any state, SHALL not change credit and SHALL pulse coin_rej the following cycle.
REQ-023 Outputs shipping, hop_req, credit, pay_cnt, coin_rej, err SHALL be registered.

Reset
REQ-024 rst_n low SHALL immediately force state IDLE, credit 0, pay_cnt 0, shipping 0, hop_req 0, coin_rej 0, err 0, timeout counter 0.
REQ-025 Reset mid-PAYOUT SHALL abandon remaining change without a further hop_req.
REQ-026 ERROR SHALL be exited only by reset.

Configuration
REQ-027 Macro VEND_HOP_TIMEOUT_EN defined: counter runs while hop_req = 1 and hop_ack = 0, clears on hop_ack; on reaching TIMEOUT, state ERROR, err = 1, hop_req = 0, pay_cnt held.
REQ-028 Macro undefined: no counter; PAYOUT waits indefinitely; err tied 0; ERROR unreachable.

Verification
REQ-029 PRICE=5; coins 001,011,011 on consecutive cycles -> credit 1,3,5; shipping pulse next cycle; pay_cnt 0; back to IDLE; hop_req never high.
REQ-030 PRICE=5; coin 101 -> shipping 1 cycle, pay_cnt 5; hop_ack every 3rd cycle -> pay_cnt 4..0, exactly 5 acks, then hop_req low.
REQ-031 Coin 011 then cancel with same-cycle coin 001 -> no shipping, pay_cnt 3, three acks to IDLE.
REQ-032 Coin 101 during PAYOUT and coin 010 in IDLE -> coin_rej pulse next cycle each, credit unchanged.
REQ-033 VEND_HOP_TIMEOUT_EN, TIMEOUT=8, no hop_ack in PAYOUT -> after 8 cycles err=1, hop_req=0, pay_cnt held; coin rejected; rst_n low clears all.
REQ-034 rst_n asserted asynchronously mid-PAYOUT with pay_cnt 3 -> all outputs 0 before the next clk edge.
